if_fetch_stage: RTL

//  Instruction-fetch stage: owns the PC, drives a single-outstanding request to the instruction

---
 rtl/if_fetch_stage.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction-fetch stage: PC, single-outstanding IMEM fetch, fetch buffer, IF/ID register
//
// Optional feature macro: IF_RVALID_BYPASS_EN
//   defined   : the response word is forwarded to IF/ID and next-PC logic in the im_rvalid
//               cycle; with PC_write=1 the FSM goes straight from WAIT back to REQ.
//   undefined : IF/ID data and IM_stall come only from the registered fetch buffer.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   PC_write                   PC may advance/redirect this cycle (hazard controller)
//   IF_regwrite                IF/ID register may load this cycle (hazard controller)
//   instruction_flush          IF/ID loads NOP_INSTR with ID_valid=0
//   BranchControl[1:0]         0:PC+4 1:pc_immrs1 2:pc_imm 3:PC+4
//   pc_imm, pc_immrs1          branch/jump targets from EXE
//   CSR_control, CSR_ret       trap / mret redirect requests
//   csr_trap_pc, csr_ret_pc    trap and return targets
//   im_req, im_addr            instruction-memory request
//   im_gnt                     request accepted
//   im_rvalid, im_rdata        instruction-memory response
//   IM_stall                   no fetched instruction available
//   ID_pc, ID_instr, ID_valid  IF/ID pipeline register

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PC_write,
    input  logic        IF_regwrite,
    input  logic        instruction_flush,
    input  logic [1:0]  BranchControl,
    input  logic [31:0] pc_imm,
    input  logic [31:0] pc_immrs1,
    input  logic        CSR_control,
    input  logic        CSR_ret,
    input  logic [31:0] csr_trap_pc,
    input  logic [31:0] csr_ret_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic        IM_stall,
    output logic [31:0] ID_pc,
    output logic [31:0] ID_instr,
    output logic        ID_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] fb_pc;
    logic [31:0] fb_instr;
    logic        fb_valid;
    logic        im_req_q;

    logic        bypass_hit;
    logic        fetch_ready;
    logic [31:0] fwd_pc;
    logic [31:0] fwd_instr;
    logic [31:0] target;
    logic [31:0] next_pc;

`ifdef IF_RVALID_BYPASS_EN
    assign bypass_hit = (state == WAIT) & im_rvalid;
`else
    assign bypass_hit = 1'b0;
`endif

    // fb_valid is set exactly while the FSM sits in HOLD, so it doubles as the
    // "buffered word available" flag.
    assign fetch_ready = fb_valid | bypass_hit;
    assign fwd_pc      = bypass_hit ? pc       : fb_pc;
    assign fwd_instr   = bypass_hit ? im_rdata : fb_instr;

    // Redirect priority: trap > mret > jalr-style > branch/jal > sequential.
    always_comb begin
        target = fwd_pc + 32'd4;
        if (CSR_control)
            target = csr_trap_pc;
        else if (CSR_ret)
            target = csr_ret_pc;
        else if (BranchControl == 2'd1)
            target = pc_immrs1;
        else if (BranchControl == 2'd2)
            target = pc_imm;
        next_pc = {target[31:2], 2'b00};
    end

    assign im_req   = im_req_q;
    assign im_addr  = pc;
    assign IM_stall = ~fetch_ready;

    // Fetch FSM. im_req is registered and set on every transition into REQ, so
    // it rises together with the new pc and im_addr cannot move while it is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            fb_pc    <= RESET_PC;
            fb_instr <= NOP_INSTR;
            fb_valid <= 1'b0;
            im_req_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    im_req_q <= 1'b1;
                end
                REQ: begin
                    if (im_gnt) begin
                        state    <= WAIT;
                        im_req_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (im_rvalid) begin
                        fb_instr <= im_rdata;
                        fb_pc    <= pc;
`ifdef IF_RVALID_BYPASS_EN
                        if (PC_write) begin
                            pc       <= next_pc;
                            state    <= REQ;
                            im_req_q <= 1'b1;
                        end else
`endif
                        begin
                            fb_valid <= 1'b1;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // PC_write=0 freezes pc and the buffer (load-use, DM/CSR stall).
                    if (PC_write) begin
                        pc       <= next_pc;
                        fb_valid <= 1'b0;
                        state    <= REQ;
                        im_req_q <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    im_req_q <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID pipeline register; flush wins over a normal load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ID_pc    <= 32'd0;
            ID_instr <= NOP_INSTR;
            ID_valid <= 1'b0;
        end else if (instruction_flush) begin
            ID_pc    <= fwd_pc;
            ID_instr <= NOP_INSTR;
            ID_valid <= 1'b0;
        end else if (IF_regwrite) begin
            if (fetch_ready) begin
                ID_pc    <= fwd_pc;
                ID_instr <= fwd_instr;
                ID_valid <= 1'b1;
            end else begin
                ID_valid <= 1'b0;
            end
        end
    end

endmodule
